draw_objects_n: RTL and testbench
=================================

# draw_objects_n

Parametrised successor to the fixed two-paddle/one-ball renderer: composites `NUM_OBJS` rectangular objects onto the pixel stream with fixed priority. Latches object positions once per frame to avoid tearing, and pipelines the hit test. It can also report per-frame pixel-overlap collisions between object 0 (the ball) and every other object. It sits between the movement/AI modules and the VGA output stage.

## Interface
Parameters:
- `NUM_OBJS`, 3: number of objects, 2–8; index 0 is the ball.
- `DISP_COLS`, 800: visible columns.
- `DISP_ROWS`, 600: visible rows.
- `COORD_W`, 12: counter/coordinate width.
- `SIZE_W`, 8: half-size width.
- `RGB_W`, 8: colour width.
- `BG_COLOR`, 0: colour where no object is hit.

Ports:
- `clk` in, 1: pixel clock.
- `rst` in, 1: asynchronous, active-high reset.
- `col_counter` in, `COORD_W`: current column.
- `row_counter` in, `COORD_W`: current row.
- `obj_center_col` in, `NUM_OBJS*COORD_W`: object k centre column at slice k.
- `obj_center_row` in, `NUM_OBJS*COORD_W`: centre row per object.
- `obj_half_w` in, `NUM_OBJS*SIZE_W`: half-width; 0 makes the object invisible.
- `obj_half_h` in, `NUM_OBJS*SIZE_W`: half-height.
- `obj_color` in, `NUM_OBJS*RGB_W`: colour per object.
- `obj_enable` in, `NUM_OBJS`: per-object draw enable.
- `rgb` out, `RGB_W`: composited pixel.
- `collision` out, `NUM_OBJS-1`: bit k-1 is set when object 0 overlapped object k last frame.
- `collision_valid` out, 1: one-cycle pulse when `collision` updates.

## Operation
- **Frame start** is the cycle where `col_counter==0 && row_counter==0`.
  - All object inputs are copied into shadow registers.
  - Drawing uses shadow values only, so mid-frame input changes are invisible until the next frame.
- **Hit test** for object k:
  - `en_k && col+hw > cc && col < cc+hw && row+hh > cr && row < cr+hh`.
  - Sums are computed in `COORD_W+1` bits, so there is no wrap near 0 or the maximum coordinate.
  - Drawn extent is `2*hw-1` × `2*hh-1`.
- **Visible area** is `col<DISP_COLS && row<DISP_ROWS`. Outside it, every hit is forced to 0 and `rgb=BG_COLOR`.
- **Priority**: the lowest hit index wins; its colour is output. No hit gives `BG_COLOR`.
- **Collision accumulator** (when compiled in):
  - Sticky bit k-1 sets on any visible pixel where hit0 and hitk are both 1.
  - At frame start: accumulator goes to `collision`, `collision_valid` pulses, accumulator clears.
  - If a hit pair and frame start land in the same cycle, the pair belongs to the new frame.
- **After reset**:
  - The first frame start loads shadows but does not pulse `collision_valid`; a `primed` flag suppresses it.
  - Reporting begins at the second frame start.
- **Reset values**:
  - `rgb=BG_COLOR`, `collision=0`, `collision_valid=0`.
  - Shadow registers, accumulator, `primed` and pipeline registers are all 0, so all objects are invisible.
- Reset asserted mid-frame aborts the frame; behaviour restarts as from power-up.

## Timing
- Stage 1 registers the per-object hit vector and the visible flag. Stage 2 registers the priority-selected `rgb`.
- Latency from counters to `rgb` is exactly 2 cycles; downstream sync must be delayed 2 cycles to match.
- Shadow load happens at the clock edge ending the frame-start cycle. The frame-start pixel itself uses the previous shadows.
- Collision accumulation samples the stage-1 hit vector. `collision`/`collision_valid` update 2 cycles after the frame-start counter value.
- Throughput is one pixel per clock, with no stalls.

## Configuration
- `DRAW_OBJECTS_COLLISION_EN`
  - Defined: accumulator, `primed` logic and outputs behave as above.
  - Undefined: `collision` is tied to 0 and `collision_valid` to 0; no accumulator registers are generated.
  - Ports exist in both builds.

## Structure
- Package `draw_objects_pkg` holds:
  - Default widths `COORD_W`/`SIZE_W`/`RGB_W`.
  - `BG_COLOR` default.
  - The object-slice helper function that extracts the k-th field of a packed bus.
- Sub-module `obj_hit_test`: combinational rectangle test for one object, instantiated `NUM_OBJS` times via generate. Shadow registers, pipeline, priority mux and accumulator stay in the top module.

## Test plan
- **Priority**: obj0 at (400,300) half 3×4, obj1 at (400,300) half 5×20, colours 0xE0/0x1C. Expect pixel (400,300) `rgb=0xE0` 2 cycles later, (404,300) `0x1C`, (406,300) `BG`.
- **Tearing**: change obj1 centre row 300→100 at row 250. Expect the current frame to keep drawing at 300; the next frame draws at 100.
- **Edge clamp**: obj at centre (2,2), half 5×5. Expect columns 0–6 drawn on row 0 with no wraparound pixels at column 4095. `col≥DISP_COLS` gives `BG`.
- **Collision**: ball overlaps obj2 for one pixel in frame 2. Expect `collision=2'b10` and a 1-cycle `collision_valid` at frame-3 start. A clean frame 3 reports `2'b00` at frame-4 start. The first frame after reset gives no pulse.
- **Reset**: assert `rst` mid-frame for 3 cycles. Expect immediate `rgb=BG`, `collision=0`, and all objects invisible until the next frame start.
- **Build without macro**: identical `rgb` trace to the full build; `collision`/`collision_valid` stay constant 0.

Source files
------------

// File: rtl/draw_objects_pkg.sv
// Shared defaults and bus-slicing helper for the object renderer.
// Optional collision reporting is enabled with DRAW_OBJECTS_COLLISION_EN.
package draw_objects_pkg;

    localparam int DEF_COORD_W  = 12;
    localparam int DEF_SIZE_W   = 8;
    localparam int DEF_RGB_W    = 8;
    localparam int DEF_BG_COLOR = 0;

    localparam int SLICE_BUS_W = 256;
    localparam int SLICE_W     = 32;

    // Field k of a packed per-object bus; caller truncates to field width.
    function automatic logic [SLICE_W-1:0] obj_field(
        input logic [SLICE_BUS_W-1:0] i_bus,
        input int unsigned            i_k,
        input int unsigned            i_w
    );
        return SLICE_W'(i_bus >> (i_k * i_w));
    endfunction

endpackage

// File: rtl/draw_objects_if.sv
// Pixel-stream and per-object bundle between the game logic and renderer.
// master drives counters/objects, slave returns pixel and collision data.
interface draw_objects_if
    import draw_objects_pkg::*;
#(
    parameter int NUM_OBJS = 3,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int SIZE_W   = DEF_SIZE_W,
    parameter int RGB_W    = DEF_RGB_W
) ();

    logic [COORD_W-1:0]          col_counter;
    logic [COORD_W-1:0]          row_counter;
    logic [NUM_OBJS*COORD_W-1:0] obj_center_col;
    logic [NUM_OBJS*COORD_W-1:0] obj_center_row;
    logic [NUM_OBJS*SIZE_W-1:0]  obj_half_w;
    logic [NUM_OBJS*SIZE_W-1:0]  obj_half_h;
    logic [NUM_OBJS*RGB_W-1:0]   obj_color;
    logic [NUM_OBJS-1:0]         obj_enable;
    logic [RGB_W-1:0]            rgb;
    logic [NUM_OBJS-2:0]         collision;
    logic                        collision_valid;

    modport master (
        output col_counter, row_counter,
        output obj_center_col, obj_center_row,
        output obj_half_w, obj_half_h,
        output obj_color, obj_enable,
        input  rgb, collision, collision_valid
    );

    modport slave (
        input  col_counter, row_counter,
        input  obj_center_col, obj_center_row,
        input  obj_half_w, obj_half_h,
        input  obj_color, obj_enable,
        output rgb, collision, collision_valid
    );

endinterface

// File: rtl/obj_hit_test.sv
// Combinational rectangle hit test for one object.
// Sums are one bit wider than coordinates so edges never wrap.
module obj_hit_test
    import draw_objects_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int SIZE_W  = DEF_SIZE_W
) (
    input  logic [COORD_W-1:0] i_col,
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_cc,
    input  logic [COORD_W-1:0] i_cr,
    input  logic [SIZE_W-1:0]  i_hw,
    input  logic [SIZE_W-1:0]  i_hh,
    input  logic               i_en,
    output logic               o_hit
);

    localparam int XW = COORD_W + 1;

    logic [XW-1:0] w_col;
    logic [XW-1:0] w_row;
    logic [XW-1:0] w_cc;
    logic [XW-1:0] w_cr;
    logic [XW-1:0] w_hw;
    logic [XW-1:0] w_hh;

    assign w_col = XW'(i_col);
    assign w_row = XW'(i_row);
    assign w_cc  = XW'(i_cc);
    assign w_cr  = XW'(i_cr);
    assign w_hw  = XW'(i_hw);
    assign w_hh  = XW'(i_hh);

    assign o_hit = i_en
                && (w_col + w_hw > w_cc)
                && (w_col < w_cc + w_hw)
                && (w_row + w_hh > w_cr)
                && (w_row < w_cr + w_hh);

endmodule

// File: rtl/draw_objects_n.sv
// Priority compositor for NUM_OBJS rectangles with per-frame shadowing.
// Define DRAW_OBJECTS_COLLISION_EN to build the ball collision reporter.
module draw_objects_n
    import draw_objects_pkg::*;
#(
    parameter int NUM_OBJS  = 3,
    parameter int DISP_COLS = 800,
    parameter int DISP_ROWS = 600,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int SIZE_W    = DEF_SIZE_W,
    parameter int RGB_W     = DEF_RGB_W,
    parameter int BG_COLOR  = DEF_BG_COLOR
) (
    input logic          clk,
    input logic          rst,
    draw_objects_if.slave bus
);

    localparam logic [RGB_W-1:0] BG = RGB_W'(BG_COLOR);
    localparam int CB = NUM_OBJS * COORD_W;
    localparam int SB = NUM_OBJS * SIZE_W;
    localparam int RB = NUM_OBJS * RGB_W;

    logic          w_frame_start;
    logic          w_visible;
    logic [CB-1:0] r_cc;
    logic [CB-1:0] r_cr;
    logic [SB-1:0] r_hw;
    logic [SB-1:0] r_hh;
    logic [RB-1:0] r_color;
    logic [NUM_OBJS-1:0] r_en;

    logic [NUM_OBJS-1:0] w_hit;
    logic [NUM_OBJS-1:0] r_hit;
    logic                r_vis;
    logic [RB-1:0]       r_color_p1;
    logic [RGB_W-1:0]    w_color [NUM_OBJS];
    logic [RGB_W-1:0]    w_sel;
    logic [RGB_W-1:0]    r_rgb;

    assign w_frame_start = (bus.col_counter == '0)
                        && (bus.row_counter == '0);
    assign w_visible = (bus.col_counter < COORD_W'(DISP_COLS))
                    && (bus.row_counter < COORD_W'(DISP_ROWS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc    <= '0;
            r_cr    <= '0;
            r_hw    <= '0;
            r_hh    <= '0;
            r_color <= '0;
            r_en    <= '0;
        end else if (w_frame_start) begin
            r_cc    <= bus.obj_center_col;
            r_cr    <= bus.obj_center_row;
            r_hw    <= bus.obj_half_w;
            r_hh    <= bus.obj_half_h;
            r_color <= bus.obj_color;
            r_en    <= bus.obj_enable;
        end
    end

    for (genvar k = 0; k < NUM_OBJS; k++) begin : g_obj
        logic [COORD_W-1:0] w_cc;
        logic [COORD_W-1:0] w_cr;
        logic [SIZE_W-1:0]  w_hw;
        logic [SIZE_W-1:0]  w_hh;

        assign w_cc = COORD_W'(obj_field(SLICE_BUS_W'(r_cc), k, COORD_W));
        assign w_cr = COORD_W'(obj_field(SLICE_BUS_W'(r_cr), k, COORD_W));
        assign w_hw = SIZE_W'(obj_field(SLICE_BUS_W'(r_hw), k, SIZE_W));
        assign w_hh = SIZE_W'(obj_field(SLICE_BUS_W'(r_hh), k, SIZE_W));
        assign w_color[k] =
            RGB_W'(obj_field(SLICE_BUS_W'(r_color_p1), k, RGB_W));

        obj_hit_test #(
            .COORD_W (COORD_W),
            .SIZE_W  (SIZE_W)
        ) u_hit (
            .i_col (bus.col_counter),
            .i_row (bus.row_counter),
            .i_cc  (w_cc),
            .i_cr  (w_cr),
            .i_hw  (w_hw),
            .i_hh  (w_hh),
            .i_en  (r_en[k]),
            .o_hit (w_hit[k])
        );
    end

    // Colours ride along with the hits so a frame-start shadow load
    // cannot recolour a pixel already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit      <= '0;
            r_vis      <= 1'b0;
            r_color_p1 <= '0;
            r_rgb      <= BG;
        end else begin
            r_hit      <= w_visible ? w_hit : '0;
            r_vis      <= w_visible;
            r_color_p1 <= r_color;
            r_rgb      <= r_vis ? w_sel : BG;
        end
    end

    always_comb begin
        w_sel = BG;
        for (int k = NUM_OBJS - 1; k >= 0; k--) begin
            if (r_hit[k]) w_sel = w_color[k];
        end
    end

    assign bus.rgb = r_rgb;

`ifdef DRAW_OBJECTS_COLLISION_EN
    logic                r_fs1;
    logic                r_primed;
    logic                r_cvalid;
    logic [NUM_OBJS-2:0] r_acc;
    logic [NUM_OBJS-2:0] r_coll;
    logic [NUM_OBJS-2:0] w_pair;

    always_comb begin
        w_pair = '0;
        for (int k = 1; k < NUM_OBJS; k++) begin
            w_pair[k-1] = r_hit[0] & r_hit[k];
        end
    end

    // r_fs1 marks stage 1 holding the frame-start pixel, which
    // already belongs to the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fs1    <= 1'b0;
            r_primed <= 1'b0;
            r_cvalid <= 1'b0;
            r_acc    <= '0;
            r_coll   <= '0;
        end else begin
            r_fs1    <= w_frame_start;
            r_cvalid <= 1'b0;
            if (r_fs1) begin
                r_acc    <= w_pair;
                r_primed <= 1'b1;
                if (r_primed) begin
                    r_coll   <= r_acc;
                    r_cvalid <= 1'b1;
                end
            end else begin
                r_acc <= r_acc | w_pair;
            end
        end
    end

    assign bus.collision       = r_coll;
    assign bus.collision_valid = r_cvalid;
`else
    assign bus.collision       = '0;
    assign bus.collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_draw_objects_n.sv
// Directed vector bench for draw_objects_n (3 objects, 800x600).
// Collision expectations follow DRAW_OBJECTS_COLLISION_EN.
module tb_draw_objects_n;
    import draw_objects_pkg::*;

    localparam int N  = 3;
    localparam int CW = 12;
    localparam int SW = 8;
    localparam int RW = 8;

`ifdef DRAW_OBJECTS_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif
    localparam logic [3:0] PULSE = COLL ? 4'b0010 : 4'b0000;

    typedef struct {
        int col;
        int row;
        int exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    draw_objects_if #(
        .NUM_OBJS (N), .COORD_W (CW), .SIZE_W (SW), .RGB_W (RW)
    ) bus ();

    draw_objects_n #(
        .NUM_OBJS  (N),
        .DISP_COLS (800),
        .DISP_ROWS (600),
        .COORD_W   (CW),
        .SIZE_W    (SW),
        .RGB_W     (RW),
        .BG_COLOR  (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.col_counter = CW'(1000);
        bus.row_counter = CW'(1000);
    endtask

    task automatic set_obj(input int k, input int cc, input int cr,
                           input int hw, input int hh, input int color,
                           input bit en);
        bus.obj_center_col[k*CW +: CW] = CW'(cc);
        bus.obj_center_row[k*CW +: CW] = CW'(cr);
        bus.obj_half_w[k*SW +: SW]     = SW'(hw);
        bus.obj_half_h[k*SW +: SW]     = SW'(hh);
        bus.obj_color[k*RW +: RW]      = RW'(color);
        bus.obj_enable[k]              = en;
    endtask

    task automatic pix(input int c, input int r, input int exp,
                       input string name);
        @(negedge clk);
        bus.col_counter = CW'(c);
        bus.row_counter = CW'(r);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1 chk(name, 32'(bus.rgb), exp);
    endtask

    task automatic fs();
        @(negedge clk);
        bus.col_counter = '0;
        bus.row_counter = '0;
        @(negedge clk);
        idle();
    endtask

    task automatic fs_check(input int exp_coll, input logic [3:0] exp_pat,
                            input string name);
        logic [3:0] pat;
        logic [N-2:0] coll;
        pat  = '0;
        coll = '0;
        @(negedge clk);
        bus.col_counter = '0;
        bus.row_counter = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pat[i] = bus.collision_valid;
            if (i == 0) idle();
            if (i == 1) coll = bus.collision;
        end
        chk({name, "_valid"}, 32'(pat), 32'(exp_pat));
        chk({name, "_coll"}, 32'(coll), exp_coll);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setup_priority();
        set_obj(0, 400, 300, 3, 4, 'hE0, 1'b1);
        set_obj(1, 400, 300, 5, 20, 'h1C, 1'b1);
        set_obj(2, 0, 0, 0, 0, 'h03, 1'b0);
    endtask

    vec_t pv[12];
    vec_t ev[14];

    initial begin
        pv[0]  = '{400, 300, 'hE0};
        pv[1]  = '{404, 300, 'h1C};
        pv[2]  = '{406, 300, 'h00};
        pv[3]  = '{405, 300, 'h00};
        pv[4]  = '{402, 300, 'hE0};
        pv[5]  = '{403, 300, 'h1C};
        pv[6]  = '{400, 303, 'hE0};
        pv[7]  = '{400, 304, 'h1C};
        pv[8]  = '{400, 319, 'h1C};
        pv[9]  = '{400, 320, 'h00};
        pv[10] = '{396, 281, 'h1C};
        pv[11] = '{395, 300, 'h00};

        ev[0]  = '{1, 0, 'h03};
        ev[1]  = '{6, 0, 'h03};
        ev[2]  = '{7, 0, 'h00};
        ev[3]  = '{0, 1, 'h03};
        ev[4]  = '{0, 6, 'h03};
        ev[5]  = '{0, 7, 'h00};
        ev[6]  = '{4095, 0, 'h00};
        ev[7]  = '{4095, 2, 'h00};
        ev[8]  = '{799, 300, 'h1C};
        ev[9]  = '{800, 300, 'h00};
        ev[10] = '{791, 300, 'h1C};
        ev[11] = '{790, 300, 'h00};
        ev[12] = '{300, 599, 'hE0};
        ev[13] = '{300, 600, 'h00};

        rst = 1'b1;
        idle();
        bus.obj_center_col = '0;
        bus.obj_center_row = '0;
        bus.obj_half_w     = '0;
        bus.obj_half_h     = '0;
        bus.obj_color      = '0;
        bus.obj_enable     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", 32'(bus.rgb), 0);
        chk("reset_coll", 32'(bus.collision), 0);
        chk("reset_valid", 32'(bus.collision_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        setup_priority();
        pix(400, 300, 'h00, "pre_fs_invisible");
        fs_check(0, 4'b0000, "first_fs");

        @(negedge clk);
        bus.col_counter = CW'(400);
        bus.row_counter = CW'(300);
        @(posedge clk);
        #1 chk("lat_1cyc", 32'(bus.rgb), 'h00);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1 chk("lat_2cyc", 32'(bus.rgb), 'hE0);
        @(posedge clk);
        #1 chk("lat_3cyc", 32'(bus.rgb), 'h00);

        for (int i = 0; i < 12; i++)
            pix(pv[i].col, pv[i].row, pv[i].exp, $sformatf("pri_%0d", i));

        set_obj(1, 400, 100, 5, 20, 'h1C, 1'b1);
        pix(404, 300, 'h1C, "tear_old_pos");
        pix(404, 100, 'h00, "tear_new_hidden");
        fs();
        pix(404, 100, 'h1C, "tear_next_new");
        pix(404, 300, 'h00, "tear_next_old");

        set_obj(0, 300, 600, 10, 10, 'hE0, 1'b1);
        set_obj(1, 800, 300, 10, 10, 'h1C, 1'b1);
        set_obj(2, 2, 2, 5, 5, 'h03, 1'b1);
        fs();
        for (int i = 0; i < 14; i++)
            pix(ev[i].col, ev[i].row, ev[i].exp, $sformatf("edge_%0d", i));

        do_reset();
        set_obj(0, 100, 100, 2, 2, 'hE0, 1'b1);
        set_obj(1, 500, 500, 2, 2, 'h1C, 1'b1);
        set_obj(2, 104, 100, 2, 2, 'h03, 1'b1);
        fs_check(0, 4'b0000, "coll_f1");
        pix(101, 101, 'hE0, "coll_f1_px");
        set_obj(2, 102, 102, 2, 2, 'h03, 1'b1);
        fs_check(0, PULSE, "coll_f2");
        pix(101, 101, 'hE0, "coll_f2_ball");
        pix(103, 103, 'h03, "coll_f2_obj2");
        set_obj(2, 104, 100, 2, 2, 'h03, 1'b1);
        fs_check(COLL ? 2 : 0, PULSE, "coll_f3");
        pix(101, 101, 'hE0, "coll_f3_ball");
        pix(104, 100, 'h03, "coll_f3_obj2");
        fs_check(0, PULSE, "coll_f4");

        setup_priority();
        fs();
        pix(400, 300, 'hE0, "pre_rst");
        @(negedge clk);
        bus.col_counter = CW'(400);
        bus.row_counter = CW'(300);
        @(posedge clk);
        @(posedge clk);
        #1 chk("hold_rgb", 32'(bus.rgb), 'hE0);
        rst = 1'b1;
        #1;
        chk("midrst_rgb", 32'(bus.rgb), 0);
        chk("midrst_coll", 32'(bus.collision), 0);
        chk("midrst_valid", 32'(bus.collision_valid), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        pix(400, 300, 'h00, "post_rst_invisible");
        fs_check(0, 4'b0000, "post_rst_fs");
        pix(400, 300, 'hE0, "post_rst_drawn");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
